// File: rtl/data_mem_resp_pkg.sv
// ============================================================================
// data_mem_resp_pkg : shared constants and helpers for the data-memory responder
// Rev 1.0
// ============================================================================
`default_nettype none

package data_mem_resp_pkg;

  localparam logic [15:0] MMIO_BASE   = 16'hBFAF;

  localparam logic [15:0] OFF_LED     = 16'h0000;
  localparam logic [15:0] OFF_SWITCH  = 16'h0004;
  localparam logic [15:0] OFF_TIMER   = 16'h0008;
  localparam logic [15:0] OFF_COMPARE = 16'h000C;
  localparam logic [15:0] OFF_STATUS  = 16'h0010;

  localparam logic [31:0] COMPARE_RST = 32'hFFFF_FFFF;

  // Replace the byte lanes selected by be with the matching lanes of new_w.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/data_mem_resp_if.sv
// ============================================================================
// data_mem_resp_if : MEM-stage data bus between requester and responder
// Rev 1.0
// ============================================================================
`default_nettype none

interface data_mem_resp_if;
  logic [31:0] dm_addr;
  logic [3:0]  dm_wen;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;

  modport master (output dm_addr, output dm_wen, output dm_wdata, input  dm_rdata);
  modport slave  (input  dm_addr, input  dm_wen, input  dm_wdata, output dm_rdata);
endinterface

`default_nettype wire

// File: rtl/data_mem_resp_ram_bank.sv
// ============================================================================
// dm_ram_bank : four byte-wide read-first synchronous RAMs, registered output
// Rev 1.0
// ============================================================================
`default_nettype none

module dm_ram_bank #(
  parameter int ADDR_W = 10
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic [ADDR_W-1:0] i_idx,
  input  wire logic [3:0]        i_we,
  input  wire logic [31:0]       i_wdata,
  output logic      [31:0]       o_rdata
);

  localparam int C_DEPTH = 1 << ADDR_W;

  for (genvar lane = 0; lane < 4; lane++) begin : g_lane
    logic [7:0] r_mem [0:C_DEPTH-1];
    logic [7:0] r_q;

    // Contents are deliberately left unreset; the caller gates writes during rst.
    always_ff @(posedge clk) begin
      if (i_we[lane]) r_mem[i_idx] <= i_wdata[8*lane +: 8];
    end

    always_ff @(posedge clk) begin
      if (rst) r_q <= 8'h00;
      else     r_q <= r_mem[i_idx];
    end

    assign o_rdata[8*lane +: 8] = r_q;
  end

endmodule

`default_nettype wire

// File: rtl/data_mem_resp.sv
// ============================================================================
// data_mem_resp : data RAM plus timer/IRQ/LED/switch register window
// Rev 1.0
// ============================================================================
`default_nettype none

module data_mem_resp #(
  parameter int          ADDR_W    = 10,
  parameter logic [15:0] MMIO_BASE = data_mem_resp_pkg::MMIO_BASE
) (
  input  wire logic        clk,
  input  wire logic        rst,
  data_mem_resp_if.slave   dm,
  input  wire logic [15:0] i_switches,
  output logic      [15:0] o_leds,
  output logic             o_timer_irq
);

  import data_mem_resp_pkg::*;

  logic        w_is_mmio;
  logic [15:0] w_off;
  logic [3:0]  w_ram_we;
  logic [31:0] w_ram_rdata;
  logic [31:0] w_mmio_rdata;
  logic [31:0] w_timer_inc;
  logic [31:0] w_timer_nxt;
  logic        w_irq_clr;

  logic [31:0] r_timer;
  logic [31:0] r_compare;
  logic [15:0] r_leds;
  logic        r_irq;
  logic [15:0] r_sync1;
  logic [15:0] r_sync2;
  logic [31:0] r_mmio_rdata;
  logic        r_sel_mmio;

  assign w_is_mmio = (dm.dm_addr[31:16] == MMIO_BASE);
  assign w_off     = dm.dm_addr[15:0];
  assign w_ram_we  = (w_is_mmio || rst) ? 4'b0000 : dm.dm_wen;

  dm_ram_bank #(.ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .rst     (rst),
    .i_idx   (dm.dm_addr[ADDR_W+1:2]),
    .i_we    (w_ram_we),
    .i_wdata (dm.dm_wdata),
    .o_rdata (w_ram_rdata)
  );

  // A TIMER write overrides only its enabled lanes; the rest keep counting.
  assign w_timer_inc = r_timer + 32'd1;
  assign w_timer_nxt = (w_is_mmio && w_off == OFF_TIMER)
                     ? lane_merge(w_timer_inc, dm.dm_wdata, dm.dm_wen)
                     : w_timer_inc;
  assign w_irq_clr   = w_is_mmio && (w_off == OFF_STATUS) && dm.dm_wen[0] && dm.dm_wdata[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer   <= 32'd0;
      r_compare <= COMPARE_RST;
      r_leds    <= 16'h0000;
      r_irq     <= 1'b0;
      r_sync1   <= 16'h0000;
      r_sync2   <= 16'h0000;
    end else begin
      r_timer <= w_timer_nxt;
      r_sync1 <= i_switches;
      r_sync2 <= r_sync1;
      // Set has priority over a same-cycle clear.
      r_irq   <= (r_timer == r_compare) | (r_irq & ~w_irq_clr);
      if (w_is_mmio && w_off == OFF_COMPARE)
        r_compare <= lane_merge(r_compare, dm.dm_wdata, dm.dm_wen);
      if (w_is_mmio && w_off == OFF_LED) begin
        if (dm.dm_wen[0]) r_leds[7:0]  <= dm.dm_wdata[7:0];
        if (dm.dm_wen[1]) r_leds[15:8] <= dm.dm_wdata[15:8];
      end
    end
  end

  always_comb begin
    w_mmio_rdata = 32'd0;
    case (w_off)
      OFF_LED:     w_mmio_rdata = {16'h0000, r_leds};
      OFF_SWITCH:  w_mmio_rdata = {16'h0000, r_sync2};
      OFF_TIMER:   w_mmio_rdata = r_timer;
      OFF_COMPARE: w_mmio_rdata = r_compare;
      OFF_STATUS:  w_mmio_rdata = {31'd0, r_irq};
      default:     w_mmio_rdata = 32'd0;
    endcase
  end

  // Register window data and region select so both paths share one-cycle latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mmio_rdata <= 32'd0;
      r_sel_mmio   <= 1'b0;
    end else begin
      r_mmio_rdata <= w_mmio_rdata;
      r_sel_mmio   <= w_is_mmio;
    end
  end

  assign dm.dm_rdata  = r_sel_mmio ? r_mmio_rdata : w_ram_rdata;
  assign o_leds       = r_leds;
  assign o_timer_irq  = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_resp.sv
// ============================================================================
// tb_data_mem_resp : randomized + directed bench against a cycle-level model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_data_mem_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] sw;
  logic [15:0] leds;
  logic        irq;

  data_mem_resp_if bus();

  data_mem_resp #(.ADDR_W(10), .MMIO_BASE(16'hBFAF)) dut (
    .clk         (clk),
    .rst         (rst),
    .dm          (bus.slave),
    .i_switches  (sw),
    .o_leds      (leds),
    .o_timer_irq (irq)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] A_LED  = 32'hBFAF_0000;
  localparam logic [31:0] A_SW   = 32'hBFAF_0004;
  localparam logic [31:0] A_TMR  = 32'hBFAF_0008;
  localparam logic [31:0] A_CMP  = 32'hBFAF_000C;
  localparam logic [31:0] A_STAT = 32'hBFAF_0010;

  // Reference state: word-addressed memory and the register window contents.
  logic [31:0] m_mem   [1024];
  bit          m_known [1024];
  logic [31:0] m_timer, m_compare;
  logic [15:0] m_leds;
  logic        m_irq;
  logic [15:0] m_swq [$];   // switch values seen at the last two edges, oldest first

  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] put_lanes(input logic [31:0] base, input logic [31:0] data,
                                            input logic [3:0] be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (base & ~mask) | (data & mask);
  endfunction

  // One bus cycle: drive, predict, clock, update the model, compare.
  task automatic step(input string tag, input logic [31:0] a, input logic [3:0] we,
                      input logic [31:0] wd, input bit r);
    logic [31:0] exp, nt, tmp;
    bit          exp_ok, mmio, match, clr;
    logic [15:0] off;
    int          idx;
    rst = r; bus.dm_addr = a; bus.dm_wen = we; bus.dm_wdata = wd;
    mmio = (a[31:16] == 16'hBFAF);
    off  = a[15:0];
    idx  = int'(a[11:2]);
    exp_ok = 1'b1;
    if (r) exp = 32'd0;
    else if (mmio) begin
      case (off)
        16'h0000: exp = {16'h0, m_leds};
        16'h0004: exp = {16'h0, m_swq[0]};
        16'h0008: exp = m_timer;
        16'h000C: exp = m_compare;
        16'h0010: exp = {31'h0, m_irq};
        default:  exp = 32'd0;
      endcase
    end else begin
      exp    = m_mem[idx];
      exp_ok = m_known[idx];
    end
    @(posedge clk);
    if (r) begin
      m_timer = 32'd0; m_compare = 32'hFFFF_FFFF; m_leds = 16'h0; m_irq = 1'b0;
      m_swq = '{16'h0, 16'h0};
    end else begin
      match = (m_timer == m_compare);
      clr   = mmio && off == 16'h0010 && we[0] && wd[0];
      nt    = m_timer + 32'd1;
      if (mmio) begin
        case (off)
          16'h0000: begin tmp = put_lanes({16'h0, m_leds}, wd, we & 4'b0011); m_leds = tmp[15:0]; end
          16'h0008: nt = put_lanes(nt, wd, we);
          16'h000C: m_compare = put_lanes(m_compare, wd, we);
          default: ;
        endcase
      end else if (we != 4'b0000) begin
        m_mem[idx]   = put_lanes(m_mem[idx], wd, we);
        m_known[idx] = m_known[idx] || (we == 4'b1111);
      end
      m_timer = nt;
      m_irq   = match | (m_irq & ~clr);
      m_swq.push_back(sw);
      void'(m_swq.pop_front());
    end
    #1;
    last_rd = bus.dm_rdata;
    if (exp_ok) check({tag, ":rdata"}, bus.dm_rdata, exp);
    check({tag, ":leds"}, {16'h0, leds}, {16'h0, m_leds});
    check({tag, ":irq"},  {31'h0, irq},  {31'h0, m_irq});
  endtask

  initial begin
    bit          found;
    logic [31:0] a;
    logic [3:0]  we;
    int          k;
    rst = 1'b1; sw = 16'h0; bus.dm_addr = '0; bus.dm_wen = '0; bus.dm_wdata = '0;
    m_swq = '{16'h0, 16'h0};
    for (int i = 0; i < 1024; i++) m_known[i] = 1'b0;
    #1;
    step("rst0", 32'h0, 4'h0, 32'h0, 1'b1);
    step("rst1", 32'h0, 4'h0, 32'h0, 1'b1);
    check("reset_rdata", last_rd, 32'h0);

    for (int i = 0; i < 1024; i++) step("init", 32'(i) << 2, 4'hF, $urandom, 1'b0);

    step("bl_w1", 32'h100, 4'hF, 32'h1122_3344, 1'b0);
    step("bl_w2", 32'h100, 4'b0010, 32'h0000_AA00, 1'b0);
    step("bl_rd", 32'h100, 4'h0, 32'h0, 1'b0);
    check("byte_lane", last_rd, 32'h1122_AA44);

    step("rf", 32'h100, 4'hF, 32'hDEAD_BEEF, 1'b0);
    check("read_first", last_rd, 32'h1122_AA44);
    step("rf_rd", 32'h100, 4'h0, 32'h0, 1'b0);
    check("read_after", last_rd, 32'hDEAD_BEEF);

    step("al_w", 32'h0000_0010, 4'hF, 32'hCAFE_F00D, 1'b0);
    step("al_rd", 32'h0000_1010, 4'h0, 32'h0, 1'b0);
    check("alias", last_rd, 32'hCAFE_F00D);

    step("cmp_w", A_CMP, 4'hF, 32'd20, 1'b0);
    step("tmr_w", A_TMR, 4'hF, 32'd0, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step("tmr_rd", A_TMR, 4'h0, 32'h0, 1'b0);
      if (last_rd == 32'd20) begin
        check("irq_rise", {31'h0, irq}, 32'd1);
        found = 1'b1;
      end else check("irq_low", {31'h0, irq}, 32'd0);
    end
    if (!found) check("timer_reach20", last_rd, 32'd20);

    step("clr", A_STAT, 4'b0001, 32'h1, 1'b0);
    check("irq_clr", {31'h0, irq}, 32'd0);
    step("tmr10", A_TMR, 4'hF, 32'd10, 1'b0);
    repeat (10) step("idle", 32'h200, 4'h0, 32'h0, 1'b0);
    check("irq_idle", {31'h0, irq}, 32'd0);
    step("clr_match", A_STAT, 4'b0001, 32'h1, 1'b0);
    check("set_wins", {31'h0, irq}, 32'd1);
    step("clr2", A_STAT, 4'b0001, 32'h1, 1'b0);
    check("irq_clr2", {31'h0, irq}, 32'd0);

    step("led_w", A_LED, 4'hF, 32'h0001_A5A5, 1'b0);
    check("leds", {16'h0, leds}, 32'h0000_A5A5);
    step("led_rd", A_LED, 4'h0, 32'h0, 1'b0);
    check("led_rd", last_rd, 32'h0000_A5A5);

    sw = 16'h00F0;
    repeat (3) step("sw_rd", A_SW, 4'h0, 32'h0, 1'b0);
    check("sw_sync", last_rd, 32'h0000_00F0);
    step("sw_w", A_SW, 4'hF, 32'hFFFF_FFFF, 1'b0);
    step("sw_rd2", A_SW, 4'h0, 32'h0, 1'b0);
    check("sw_ro", last_rd, 32'h0000_00F0);

    step("pre", 32'h200, 4'hF, 32'h1234_5678, 1'b0);
    step("rst_w", 32'h200, 4'hF, 32'hBAD0_BAD0, 1'b1);
    check("rst_rdata", last_rd, 32'h0);
    check("rst_leds", {16'h0, leds}, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    step("rst_rd", 32'h200, 4'h0, 32'h0, 1'b0);
    check("rst_drop", last_rd, 32'h1234_5678);
    step("rst_tmr", A_TMR, 4'h0, 32'h0, 1'b0);
    check("rst_timer", last_rd, 32'd1);
    step("rst_cmp", A_CMP, 4'h0, 32'h0, 1'b0);
    check("rst_compare", last_rd, 32'hFFFF_FFFF);

    for (int i = 0; i < 3000; i++) begin
      k = $urandom_range(0, 9);
      if (k < 6)
        a = ($urandom_range(0, 7) << 12) | ($urandom_range(0, 31) << 2) | $urandom_range(0, 3);
      else if (k < 9)
        a = {16'hBFAF, 16'($urandom_range(0, 5) * 4)};
      else
        a = {16'hBFAF, 16'h0100};
      we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      if ($urandom_range(0, 15) == 0) sw = 16'($urandom);
      step("rand", a, we, $urandom, $urandom_range(0, 99) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
